zone_scan_scheduler: RTL and testbench

Time-multiplexed scanner for the alarm's zone sensors. All zones share one analogue-mux sense line. The block walks the mux select round-robin, waits a settle time, samples, debounces each zone, and keeps a debounced zone status vector. Each accepted change is reported to the alarm state machine as a single-entry valid/ready event, and the scanner stalls rather than drop an event.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/zone_event_slot.sv | 41 ++++
 rtl/zone_scan_scheduler.sv | 140 ++++++++++++++
 tb/tb_zone_scan_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: scanner state encodings, zone-index width helper,
// scanner timing defaults and the alarm controller state codes used by the event consumer.
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StSample  = 2'd2,
    StAdvance = 2'd3
  } scan_state_e;

  localparam int unsigned DEF_DWELL_TICKS  = 2;
  localparam int unsigned DEF_DEBOUNCE_CNT = 3;

  typedef enum logic [1:0] {
    AlarmDisarmed   = 2'd0,
    AlarmArmed      = 2'd1,
    AlarmEntryDelay = 2'd2,
    AlarmTriggered  = 2'd3
  } alarm_state_e;

  // Zone-index width; never narrower than one bit.
  function automatic int unsigned zw(input int unsigned num_zones);
    return (num_zones < 2) ? 1 : $clog2(num_zones);
  endfunction

endpackage

// File: rtl/zone_event_slot.sv
// Single-entry valid/ready holding register for zone change events.
// o_free is high when a load may be accepted this cycle (empty, or draining now).
module zone_event_slot #(
  parameter int unsigned ZW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_ack,
  input  logic [ZW-1:0] i_zone,
  input  logic          i_level,
  output logic          o_valid,
  output logic [ZW-1:0] o_zone,
  output logic          o_level,
  output logic          o_free
);

  logic          r_valid;
  logic [ZW-1:0] r_zone;
  logic          r_level;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_zone  <= '0;
      r_level <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_zone  <= i_zone;
      r_level <= i_level;
    end else if (i_ack && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free  = !r_valid || i_ack;
  assign o_valid = r_valid;
  assign o_zone  = r_zone;
  assign o_level = r_level;

endmodule

// File: rtl/zone_scan_scheduler.sv
// Round-robin zone sensor scanner with per-zone debounce and a single-entry change event.
// Optional ZONE_MASK_EN adds iZONE_MASK: masked zones sample as 0.
module zone_scan_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ZONES    = 3,
  parameter int unsigned DWELL_TICKS  = DEF_DWELL_TICKS,
  parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic                        iEN,
  input  logic                        iSENSE,
`ifdef ZONE_MASK_EN
  input  logic [NUM_ZONES-1:0]        iZONE_MASK,
`endif
  output logic [zw(NUM_ZONES)-1:0]    oZONE_SEL,
  output logic [NUM_ZONES-1:0]        oZONE_STATUS,
  output logic                        oEVENT_VALID,
  input  logic                        iEVENT_READY,
  output logic [zw(NUM_ZONES)-1:0]    oEVENT_ZONE,
  output logic                        oEVENT_LEVEL,
  output logic                        oSCAN_DONE
);

  localparam int unsigned ZW  = zw(NUM_ZONES);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned DWW = $clog2(DWELL_TICKS + 1);

  localparam logic [ZW-1:0]  LastZone  = ZW'(NUM_ZONES - 1);
  localparam logic [DBW-1:0] DebLast   = DBW'(DEBOUNCE_CNT - 1);
  localparam logic [DWW-1:0] DwellLast = DWW'(DWELL_TICKS - 1);

  scan_state_e           r_state, w_state_d;
  logic [ZW-1:0]         r_sel, w_sel_d;
  logic [DWW-1:0]        r_dwell, w_dwell_d;
  logic [NUM_ZONES-1:0]  r_status, w_status_d;
  logic [DBW-1:0]        r_deb [NUM_ZONES];
  logic [DBW-1:0]        w_deb_d [NUM_ZONES];

  logic                  w_sample;
  logic                  w_differs;
  logic [DBW-1:0]        w_deb_cur;
  logic                  w_slot_free;
  logic                  w_load;

`ifdef ZONE_MASK_EN
  assign w_sample = iSENSE & ~iZONE_MASK[r_sel];
`else
  assign w_sample = iSENSE;
`endif

  assign w_differs = w_sample != r_status[r_sel];
  assign w_deb_cur = r_deb[r_sel];

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= StIdle;
      r_sel    <= '0;
      r_dwell  <= '0;
      r_status <= '0;
      r_deb    <= '{default: '0};
    end else begin
      r_state  <= w_state_d;
      r_sel    <= w_sel_d;
      r_dwell  <= w_dwell_d;
      r_status <= w_status_d;
      r_deb    <= w_deb_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_sel_d    = r_sel;
    w_dwell_d  = r_dwell;
    w_status_d = r_status;
    w_deb_d    = r_deb;
    w_load     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_sel_d   = '0;
        w_dwell_d = '0;
        if (iEN) w_state_d = StSettle;
      end
      StSettle: begin
        if (r_dwell == DwellLast) begin
          w_dwell_d = '0;
          w_state_d = StSample;
        end else begin
          w_dwell_d = r_dwell + 1'b1;
        end
      end
      StSample: begin
        if (!w_differs) begin
          w_deb_d[r_sel] = '0;
          w_state_d      = StAdvance;
        end else if (w_deb_cur < DebLast) begin
          w_deb_d[r_sel] = w_deb_cur + 1'b1;
          w_state_d      = StAdvance;
        end else if (w_slot_free) begin
          w_status_d[r_sel] = w_sample;
          w_deb_d[r_sel]    = '0;
          w_load            = 1'b1;
          w_state_d         = StAdvance;
        end
        // Slot busy: stay here holding the counter so the change is never dropped.
      end
      StAdvance: begin
        if (!iEN) begin
          w_sel_d   = '0;
          w_state_d = StIdle;
        end else begin
          w_sel_d   = (r_sel == LastZone) ? '0 : r_sel + 1'b1;
          w_state_d = StSettle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  zone_event_slot #(
    .ZW(ZW)
  ) u_event_slot (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_load  (w_load),
    .i_ack   (iEVENT_READY),
    .i_zone  (r_sel),
    .i_level (w_sample),
    .o_valid (oEVENT_VALID),
    .o_zone  (oEVENT_ZONE),
    .o_level (oEVENT_LEVEL),
    .o_free  (w_slot_free)
  );

  assign oZONE_SEL    = r_sel;
  assign oZONE_STATUS = r_status;
  assign oSCAN_DONE   = (r_state == StAdvance) && (r_sel == LastZone);

endmodule

// File: tb/tb_zone_scan_scheduler.sv
// Directed bench for zone_scan_scheduler at default parameters (3 zones, 4-cycle visit,
// 12-cycle sweep, 3-sample debounce).
module tb_zone_scan_scheduler;

  logic       iCLK;
  logic       iRST_N;
  logic       iEN;
  logic       iSENSE;
  logic [1:0] oZONE_SEL;
  logic [2:0] oZONE_STATUS;
  logic       oEVENT_VALID;
  logic       iEVENT_READY;
  logic [1:0] oEVENT_ZONE;
  logic       oEVENT_LEVEL;
  logic       oSCAN_DONE;

  logic [2:0] sense_vec;
  int         checks;
  int         passes;

  zone_scan_scheduler dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iEN          (iEN),
    .iSENSE       (iSENSE),
`ifdef ZONE_MASK_EN
    .iZONE_MASK   (3'b000),
`endif
    .oZONE_SEL    (oZONE_SEL),
    .oZONE_STATUS (oZONE_STATUS),
    .oEVENT_VALID (oEVENT_VALID),
    .iEVENT_READY (iEVENT_READY),
    .oEVENT_ZONE  (oEVENT_ZONE),
    .oEVENT_LEVEL (oEVENT_LEVEL),
    .oSCAN_DONE   (oSCAN_DONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // The sense line reflects whichever zone the mux currently selects.
  always_comb begin
    case (oZONE_SEL)
      2'd0:    iSENSE = sense_vec[0];
      2'd1:    iSENSE = sense_vec[1];
      2'd2:    iSENSE = sense_vec[2];
      default: iSENSE = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; iEN = 1'b0; iEVENT_READY = 1'b0; sense_vec = 3'b000;
    run(2);
    checks++;
    if ({oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oSCAN_DONE} !== 10'd0)
      $display("FAIL reset_outputs: got %b expected 0000000000",
               {oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oSCAN_DONE});
    else passes++;
  endtask

  task automatic test_sweep();
    logic [1:0] exp_sel;
    logic       exp_done;
    iRST_N = 1'b1; iEN = 1'b1; sense_vec = 3'b000;
    for (int t = 1; t <= 24; t++) begin
      tick();
      exp_sel  = 2'(((t - 1) / 4) % 3);
      exp_done = (t % 12) == 0;
      checks++;
      if ({oZONE_SEL, oSCAN_DONE, oEVENT_VALID} !== {exp_sel, exp_done, 1'b0})
        $display("FAIL sweep_t%0d: sel/done/valid got %b expected %b", t,
                 {oZONE_SEL, oSCAN_DONE, oEVENT_VALID}, {exp_sel, exp_done, 1'b0});
      else passes++;
    end
  endtask

  task automatic test_event();
    sense_vec = 3'b010;
    run(24);
    run(7);
    checks++;
    if (oEVENT_VALID !== 1'b0) $display("FAIL event_early: valid got %b expected 0", oEVENT_VALID);
    else passes++;
    tick();
    checks++;
    if ({oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS} !== {1'b1, 2'd1, 1'b1, 3'b010})
      $display("FAIL event_zone1: valid/zone/level/status got %b expected %b",
               {oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS},
               {1'b1, 2'd1, 1'b1, 3'b010});
    else passes++;
    iEVENT_READY = 1'b1;
    tick();
    iEVENT_READY = 1'b0;
    checks++;
    if (oEVENT_VALID !== 1'b0) $display("FAIL event_ack: valid got %b expected 0", oEVENT_VALID);
    else passes++;
    run(3);
    checks++;
    if (oSCAN_DONE !== 1'b1) $display("FAIL event_sweep_end: done got %b expected 1", oSCAN_DONE);
    else passes++;
  endtask

  task automatic test_glitch();
    logic [2:0] pattern [6];
    pattern = '{3'b110, 3'b110, 3'b010, 3'b110, 3'b110, 3'b010};
    for (int s = 0; s < 6; s++) begin
      sense_vec = pattern[s];
      run(12);
      checks++;
      if ({oEVENT_VALID, oZONE_STATUS} !== {1'b0, 3'b010})
        $display("FAIL glitch_sweep%0d: valid/status got %b expected %b", s,
                 {oEVENT_VALID, oZONE_STATUS}, {1'b0, 3'b010});
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    iEVENT_READY = 1'b0;
    sense_vec = 3'b111;
    run(24);
    run(4);
    checks++;
    if ({oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS} !== {1'b1, 2'd0, 1'b1, 3'b011})
      $display("FAIL b2b_zone0: valid/zone/level/status got %b expected %b",
               {oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS},
               {1'b1, 2'd0, 1'b1, 3'b011});
    else passes++;
    run(8);
    checks++;
    if ({oZONE_SEL, oSCAN_DONE, oEVENT_VALID, oEVENT_ZONE} !== {2'd2, 1'b0, 1'b1, 2'd0})
      $display("FAIL b2b_stall_start: sel/done/valid/zone got %b expected %b",
               {oZONE_SEL, oSCAN_DONE, oEVENT_VALID, oEVENT_ZONE}, {2'd2, 1'b0, 1'b1, 2'd0});
    else passes++;
    run(3);
    checks++;
    if ({oZONE_SEL, oSCAN_DONE, oZONE_STATUS, oEVENT_ZONE} !== {2'd2, 1'b0, 3'b011, 2'd0})
      $display("FAIL b2b_stall_hold: sel/done/status/zone got %b expected %b",
               {oZONE_SEL, oSCAN_DONE, oZONE_STATUS, oEVENT_ZONE}, {2'd2, 1'b0, 3'b011, 2'd0});
    else passes++;
    iEVENT_READY = 1'b1;
    tick();
    iEVENT_READY = 1'b0;
    checks++;
    if ({oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS, oSCAN_DONE} !==
        {1'b1, 2'd2, 1'b1, 3'b111, 1'b1})
      $display("FAIL b2b_reload: valid/zone/level/status/done got %b expected %b",
               {oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS, oSCAN_DONE},
               {1'b1, 2'd2, 1'b1, 3'b111, 1'b1});
    else passes++;
  endtask

  task automatic test_enable_drop();
    iEVENT_READY = 1'b1;
    sense_vec = 3'b110;
    tick();
    iEVENT_READY = 1'b0;
    checks++;
    if (oEVENT_VALID !== 1'b0) $display("FAIL drop_ack: valid got %b expected 0", oEVENT_VALID);
    else passes++;
    run(4);
    iEN = 1'b0;
    run(3);
    checks++;
    if ({oZONE_SEL, oSCAN_DONE} !== {2'd1, 1'b0})
      $display("FAIL drop_advance: sel/done got %b expected %b", {oZONE_SEL, oSCAN_DONE},
               {2'd1, 1'b0});
    else passes++;
    run(3);
    checks++;
    if ({oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oSCAN_DONE} !== {2'd0, 3'b111, 1'b0, 1'b0})
      $display("FAIL drop_idle: sel/status/valid/done got %b expected %b",
               {oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oSCAN_DONE}, {2'd0, 3'b111, 1'b0, 1'b0});
    else passes++;
    iEN = 1'b1;
    run(15);
    checks++;
    if (oEVENT_VALID !== 1'b0)
      $display("FAIL resume_early: valid got %b expected 0", oEVENT_VALID);
    else passes++;
    tick();
    checks++;
    if ({oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS} !== {1'b1, 2'd0, 1'b0, 3'b110})
      $display("FAIL resume_event: valid/zone/level/status got %b expected %b",
               {oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oZONE_STATUS},
               {1'b1, 2'd0, 1'b0, 3'b110});
    else passes++;
  endtask

  task automatic test_reset_mid_stall();
    sense_vec = 3'b010;
    run(34);
    checks++;
    if ({oZONE_SEL, oSCAN_DONE, oEVENT_VALID, oEVENT_ZONE} !== {2'd2, 1'b0, 1'b1, 2'd0})
      $display("FAIL stall_before_reset: sel/done/valid/zone got %b expected %b",
               {oZONE_SEL, oSCAN_DONE, oEVENT_VALID, oEVENT_ZONE}, {2'd2, 1'b0, 1'b1, 2'd0});
    else passes++;
    iRST_N = 1'b0;
    tick();
    checks++;
    if ({oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oSCAN_DONE} !== 10'd0)
      $display("FAIL reset_mid_stall: got %b expected 0000000000",
               {oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oEVENT_ZONE, oEVENT_LEVEL, oSCAN_DONE});
    else passes++;
    iRST_N = 1'b1;
    iEN = 1'b0;
    run(3);
    checks++;
    if ({oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oSCAN_DONE} !== 7'd0)
      $display("FAIL post_reset_idle: got %b expected 0000000",
               {oZONE_SEL, oZONE_STATUS, oEVENT_VALID, oSCAN_DONE});
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_sweep();
    test_event();
    test_glitch();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
